timer_sequencer: RTL

- Initiator side of the timer go/cycles/done protocol.
- Accepts interval commands (cycle count plus repeat count) over a valid/ready port and drives an external timer's go/cycles inputs.
- Monitors the timer's done output and emits one tick pulse per completed interval.
- Sits between software-visible control logic and a timer instance; the timer shares this block's clock and reset.

---
 rtl/timer_seq_pkg.sv | 14 +
 rtl/timer_sequencer.sv | 111 +++++++++++
 2 files changed

// File: rtl/timer_seq_pkg.sv
// Shared types and constants for timer_sequencer.
// The optional statistics outputs are enabled by defining TIMER_SEQ_STATS_EN.
package timer_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // The timer sits idle (done high) for one cycle between back-to-back intervals.
  localparam int TIMER_LATENCY_EXTRA = 1;

endpackage

// File: rtl/timer_sequencer.sv
// Drives an external timer's go/cycles inputs from interval commands and ticks on each done.
// Define TIMER_SEQ_STATS_EN to add the busy_cycles and last_period outputs.
module timer_sequencer
  import timer_seq_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int REP_WIDTH = 16,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // Command port: a command is consumed on any rising edge where in_valid && in_ready;
  // in_ready is high only in IDLE and never depends on in_valid.
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_cycles,
  input  logic [REP_WIDTH-1:0] in_reps,
  input  logic                 stop,
  output logic                 timer_go,
  output logic [WIDTH-1:0]     timer_cycles,
  input  logic                 timer_done,
  output logic                 tick,
  output logic                 busy,
  output logic                 err,
  output logic [CNT_WIDTH-1:0] event_count,
`ifdef TIMER_SEQ_STATS_EN
  output logic [CNT_WIDTH-1:0] busy_cycles,
  output logic [WIDTH:0]       last_period,
`endif
  output logic [1:0]           fsm_state
);

  localparam logic [1:0] S_IDLE  = 2'(IDLE);
  localparam logic [1:0] S_ISSUE = 2'(ISSUE);
  localparam logic [1:0] S_WAIT  = 2'(WAIT);

  logic [1:0]           state;
  logic [1:0]           state_d;
  logic [REP_WIDTH-1:0] reps_left;
  logic                 stop_pending;
  logic                 accept;
  logic                 cmd_ok;
  logic                 stop_now;

  assign fsm_state = state;
  assign in_ready  = (state == S_IDLE);
  assign busy      = (state == S_ISSUE) || (state == S_WAIT);
  assign timer_go  = (state == S_ISSUE);
  assign tick      = (state == S_WAIT) && timer_done;
  assign accept    = in_valid && in_ready;
  assign cmd_ok    = (in_cycles != '0) && (in_reps != '0);
  // A stop raised in the very cycle the interval completes still prevents a reissue.
  assign stop_now  = stop_pending || stop;

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (accept && cmd_ok) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (timer_done) begin
          if ((reps_left > REP_WIDTH'(1)) && !stop_now) state_d = S_ISSUE;
          else                                        state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      reps_left    <= '0;
      stop_pending <= 1'b0;
      err          <= 1'b0;
      timer_cycles <= '0;
      event_count  <= '0;
    end else begin
      state <= state_d;
      err   <= accept && (in_cycles == '0);
      if (accept && cmd_ok) begin
        timer_cycles <= in_cycles;
        reps_left    <= in_reps;
      end else if (tick) begin
        reps_left <= reps_left - REP_WIDTH'(1);
      end
      if (tick) event_count <= event_count + CNT_WIDTH'(1);
      if (state_d == S_IDLE)  stop_pending <= 1'b0;
      else if (busy && stop)  stop_pending <= 1'b1;
    end
  end

`ifdef TIMER_SEQ_STATS_EN
  logic [WIDTH:0] period_cnt;

  // period_cnt equals the number of cycles since go, so it holds N on the tick cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_cycles <= '0;
      last_period <= '0;
      period_cnt  <= '0;
    end else begin
      if (busy && (busy_cycles != '1)) busy_cycles <= busy_cycles + CNT_WIDTH'(1);
      if (state == S_ISSUE)     period_cnt <= (WIDTH+1)'(1);
      else if (state == S_WAIT) period_cnt <= period_cnt + (WIDTH+1)'(1);
      if (tick) last_period <= period_cnt;
    end
  end
`endif

endmodule
